// File: rtl/byte_packer_pkg.sv
// Shared definitions for the byte packer: default lane count, state encoding
// and the byte-count width helper.
package byte_packer_pkg;

  localparam int unsigned DefaultLanes = 4;

  // Accumulator state, derived from the byte count and the pending-flush flag.
  typedef enum logic [1:0] {
    StEmpty,
    StFill,
    StFullWait,
    StFlushWait
  } pack_state_e;

  // Width needed to hold a byte count of 0..lanes.
  function automatic int unsigned cnt_width(input int unsigned lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/byte_packer_if.sv
// Byte-in / word-out bus of the byte packer. The master drives bytes and the
// downstream ready; the slave (the packer) returns busy, the word and the sum.
interface byte_packer_if
  import byte_packer_pkg::*;
#(
  parameter int unsigned LANES = DefaultLanes
) ();

  localparam int unsigned CntW = cnt_width(LANES);

  logic                 in_w;
  logic [7:0]           in_data;
  logic                 in_r;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
  logic [CntW-1:0]      out_cnt;
  logic [15:0]          sum;

  modport master (
    output in_w, in_data, flush, out_ready,
    input  in_r, out_valid, out_data, out_cnt, sum
  );

  modport slave (
    input  in_w, in_data, flush, out_ready,
    output in_r, out_valid, out_data, out_cnt, sum
  );

endinterface

// File: rtl/pack_out_reg.sv
// Output holding register: loads a packed word, holds it until taken, and
// reports when it can accept a new word (empty or draining this cycle).
module pack_out_reg #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CntW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [8*LANES-1:0] load_data_i,
  input  logic [CntW-1:0]    load_cnt_i,
  input  logic               out_ready_i,
  output logic               out_valid_o,
  output logic [8*LANES-1:0] out_data_o,
  output logic [CntW-1:0]    out_cnt_o,
  output logic               free_o
);

  logic               valid_q, valid_d;
  logic [8*LANES-1:0] data_q, data_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  assign free_o      = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_cnt_o   = cnt_q;

  // Load wins over drain so a word taken and replaced in one cycle keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
      cnt_d   = load_cnt_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output word state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/byte_packer.sv
// Packs an 8-bit byte stream little-endian into LANES-byte words, with a
// busy signal upstream, valid/ready downstream, flush of partial words and a
// running 16-bit byte sum.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int unsigned LANES = DefaultLanes
) (
  input  logic          clk,
  input  logic          rst,
  byte_packer_if.slave  bus
);

  localparam int unsigned CntW = cnt_width(LANES);
  localparam logic [CntW-1:0] FullCnt = CntW'(LANES);

  logic [LANES-1:0][7:0] acc_q, acc_d, acc_new;
  logic [CntW-1:0]       acc_cnt_q, acc_cnt_d, cnt_after;
  logic                  flush_pend_q, flush_pend_d;
  logic [15:0]           sum_q, sum_d;
  pack_state_e           state_q, state_d;

  logic                  in_r, accept, complete, want_xfer, load, out_free;
  logic [8*LANES-1:0]    load_word;

  // Busy whenever the accumulator is full or a flush is waiting for the output.
  assign in_r      = (state_q == StFullWait) || (state_q == StFlushWait);
  assign accept    = bus.in_w && !in_r;
  assign load_word = acc_new;
  assign bus.in_r  = in_r;
  assign bus.sum   = sum_q;

  // Accumulator, byte count, pending flush and sum next-state.
  always_comb begin
    acc_new      = acc_q;
    flush_pend_d = flush_pend_q;
    sum_d        = sum_q;
    cnt_after    = acc_cnt_q + {{(CntW-1){1'b0}}, accept};
    for (int unsigned i = 0; i < LANES; i++) begin
      if (accept && (acc_cnt_q == CntW'(i))) begin
        acc_new[i] = bus.in_data;
      end
    end
    if (accept) begin
      sum_d = sum_q + {8'h00, bus.in_data};
    end
    complete  = (cnt_after == FullCnt);
    want_xfer = complete || flush_pend_q || (bus.flush && (cnt_after != '0));
    load      = want_xfer && out_free;
    if (load) begin
      // Clearing lanes on transfer keeps unused lanes of a partial word zero.
      acc_d        = '0;
      acc_cnt_d    = '0;
      flush_pend_d = 1'b0;
    end else begin
      acc_d     = acc_new;
      acc_cnt_d = cnt_after;
      // A flush that coincides with completion is redundant: the full word goes anyway.
      if (bus.flush && (cnt_after != '0) && !complete) begin
        flush_pend_d = 1'b1;
      end
    end
  end

  // State follows the registered count and pending flag.
  always_comb begin
    if (flush_pend_d) begin
      state_d = StFlushWait;
    end else if (acc_cnt_d == FullCnt) begin
      state_d = StFullWait;
    end else if (acc_cnt_d == '0) begin
      state_d = StEmpty;
    end else begin
      state_d = StFill;
    end
  end

  // Accumulator-side state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      sum_q        <= '0;
      state_q      <= StEmpty;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      sum_q        <= sum_d;
      state_q      <= state_d;
    end
  end

  pack_out_reg #(
    .LANES (LANES),
    .CntW  (CntW)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .load_data_i (load_word),
    .load_cnt_i  (cnt_after),
    .out_ready_i (bus.out_ready),
    .out_valid_o (bus.out_valid),
    .out_data_o  (bus.out_data),
    .out_cnt_o   (bus.out_cnt),
    .free_o      (out_free)
  );

endmodule

// File: tb/tb_byte_packer.sv
// Scoreboard bench for byte_packer: a byte-list model predicts words, a
// monitor compares every handshaken word, the sum is checked each cycle.
module tb_byte_packer;

  localparam int unsigned L  = 4;
  localparam int unsigned CW = $clog2(L + 1);

  typedef struct {
    logic [8*L-1:0] data;
    logic [CW-1:0]  cnt;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  byte_packer_if #(.LANES(L)) bus ();

  byte_packer #(.LANES(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  word_t       exp_q[$];
  logic [7:0]  cur[$];
  logic [15:0] sum_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Close the bytes gathered so far into one expected word.
  function automatic void emit();
    word_t e;
    e.data = '0;
    for (int i = 0; i < cur.size(); i++) e.data[8*i +: 8] = cur[i];
    e.cnt = CW'(cur.size());
    exp_q.push_back(e);
    cur.delete();
  endfunction

  // One clock of stimulus; the model follows the accepted bytes and flushes.
  task automatic step(input logic w, input logic [7:0] d, input logic f, input logic rdy);
    logic acc;
    @(negedge clk);
    bus.in_w      = w;
    bus.in_data   = d;
    bus.flush     = f;
    bus.out_ready = rdy;
    #1;
    acc = w && !bus.in_r;
    if (acc) begin
      cur.push_back(d);
      sum_m = sum_m + {8'h00, d};
      if (cur.size() == L) emit();
    end
    if (f && cur.size() > 0) emit();
    @(posedge clk);
    #1;
    chk("sum", 32'(bus.sum), 32'(sum_m));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_cnt", 32'(bus.out_cnt), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_in_r", 32'(bus.in_r), 32'd0);
    exp_q.delete();
    cur.delete();
    sum_m = '0;
    bus.in_w      = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every word taken downstream must match the head of the queue.
  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h expected no word", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 32'(bus.out_data), 32'(e.data));
          chk("word_cnt", 32'(bus.out_cnt), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       w, f, rdy;
    logic [7:0] d;
    bus.in_w      = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    do_reset();

    // Four bytes straight through.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b1);
      chk("t1_in_r", 32'(bus.in_r), 32'd0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t1_sum", 32'(bus.sum), 32'h000A);

    // Back-pressure: one word held, accumulator fills, then busy.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("t2_in_r_busy", 32'(bus.in_r), 32'd1);
    chk("t2_held", 32'(bus.out_data), 32'h13121110);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_in_r_drop", 32'(bus.in_r), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

    // Partial word flush, then a no-op flush.
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

    // Flush with the third byte while the output is busy.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 8'hCC, 1'b0, 1'b0);
    step(1'b1, 8'hDD, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("t4_in_r_pend", 32'(bus.in_r), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset with a word held and two bytes accumulated.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Sum wrap with 1024 x FF.
    do_reset();
    for (int i = 0; i < 1024; i++) step(1'b1, 8'hFF, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_sum_wrap", 32'(bus.sum), 32'h0000FC00);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      w   = ($urandom_range(0, 3) != 0);
      d   = 8'($urandom);
      f   = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      step(w, d, f, rdy);
    end

    // Drain whatever is left.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
